skipring_mc: RTL and testbench

//  Multi-channel pulse-skipping pattern generator; parametrised successor of the single-ring skipper.
//  A shared position counter walks a LEN-step ring. Each of NCH channels emits a one-cycle clock-enable

---
 rtl/skipring_mc_if.sv | 37 +++
 rtl/skipring_mc.sv | 122 ++++++++++++
 tb/tb_skipring_mc.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/skipring_mc_if.sv
// skipring_mc_if: control/status bundle for the multi-channel pulse-skipping generator.
//   e      step request             mode   0 continuous / 1 one-shot
//   go     one-shot start pulse     wr     mask write strobe
//   wch    write channel index      wimm   1 immediate / 0 deferred to wrap
//   wmask  new mask (bit p = pos p) ce     per-channel enable strobes
//   st     ring-wrap strobe         pos    position used by the next step
//   run    ring running             pend   deferred mask pending per channel
// master drives requests and reads status; slave is the generator.
interface skipring_mc_if #(
  parameter int LEN = 16,
  parameter int NCH = 4,
  parameter int PW  = $clog2(LEN),
  parameter int CW  = ($clog2(NCH) > 0) ? $clog2(NCH) : 1
);
  logic           e;
  logic           mode;
  logic           go;
  logic           wr;
  logic [CW-1:0]  wch;
  logic           wimm;
  logic [LEN-1:0] wmask;
  logic [NCH-1:0] ce;
  logic           st;
  logic [PW-1:0]  pos;
  logic           run;
  logic [NCH-1:0] pend;

  modport master (
    output e, mode, go, wr, wch, wimm, wmask,
    input  ce, st, pos, run, pend
  );

  modport slave (
    input  e, mode, go, wr, wch, wimm, wmask,
    output ce, st, pos, run, pend
  );
endinterface

// File: rtl/skipring_mc.sv
// skipring_mc: multi-channel pulse-skipping pattern generator.
// A shared position counter walks a LEN-step ring; channel c emits a one-cycle
// enable strobe on each step whose position has a 1 in its active mask.
// Masks reload immediately or deferred to the ring wrap; continuous and
// one-shot (single ring pass) modes.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    skipring_mc_if slave modport (see interface header)
//
// state   | meaning
// S_IDLE  | one-shot not armed; ring runs only in continuous mode
// S_ARMED | one-shot pass in progress; returns to idle on the wrap step
module skipring_mc #(
  parameter int LEN = 16,
  parameter int NCH = 4,
  parameter int PW  = $clog2(LEN),
  parameter int CW  = ($clog2(NCH) > 0) ? $clog2(NCH) : 1,
  parameter logic [LEN*NCH-1:0] DEF_MASK = {NCH{LEN'(16'hCCCC)}}
) (
  input  logic         clk,
  input  logic         rst_n,
  skipring_mc_if.slave bus
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_ARMED  = 1'b1;
  localparam logic [PW-1:0] POS_LAST = PW'(LEN - 1);
  localparam logic [CW:0]   NCH_W    = (CW + 1)'(NCH);

  logic [LEN-1:0] active_q [NCH];
  logic [LEN-1:0] shadow_q [NCH];
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] ce_q;
  logic           st_q;
  logic [PW-1:0]  pos_q;
  logic [0:0]     state_q;

  logic run;
  logic step;
  logic wrap;
  logic wr_ok;

  assign run   = ~bus.mode | (state_q == S_ARMED);
  assign step  = bus.e & run;
  assign wrap  = step & (pos_q == POS_LAST);
  // Channel indices beyond NCH (possible when NCH is not a power of 2) are dropped.
  assign wr_ok = bus.wr & ({1'b0, bus.wch} < NCH_W);

  // Explicit compare keeps non-power-of-2 rings from ever reaching pos >= LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else if (step) begin
      pos_q <= (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q <= '0;
      st_q <= 1'b0;
    end else begin
      st_q <= wrap;
      for (int c = 0; c < NCH; c++) begin
        ce_q[c] <= step & active_q[c][pos_q];
      end
    end
  end

  // The wrap step's own strobe reads the old active mask (ce_q above samples
  // active_q before this update). An immediate write beats a wrap commit; a
  // deferred write on the wrap step commits the old shadow and stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        active_q[c] <= DEF_MASK[c*LEN +: LEN];
        shadow_q[c] <= DEF_MASK[c*LEN +: LEN];
      end
      pend_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ok && (bus.wch == CW'(c))) begin
          if (bus.wimm) begin
            active_q[c] <= bus.wmask;
            pend_q[c]   <= 1'b0;
          end else begin
            if (wrap && pend_q[c]) begin
              active_q[c] <= shadow_q[c];
            end
            shadow_q[c] <= bus.wmask;
            pend_q[c]   <= 1'b1;
          end
        end else if (wrap && pend_q[c]) begin
          active_q[c] <= shadow_q[c];
          pend_q[c]   <= 1'b0;
        end
      end
    end
  end

  // go is only honoured in one-shot mode while idle, so a pass always
  // starts from wherever the ring is parked and ends exactly at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.mode && bus.go) state_q <= S_ARMED;
        S_ARMED: if (wrap) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ce   = ce_q;
  assign bus.st   = st_q;
  assign bus.pos  = pos_q;
  assign bus.run  = run;
  assign bus.pend = pend_q;

endmodule

// File: tb/tb_skipring_mc.sv
// tb_skipring_mc: scoreboard bench for skipring_mc.
// DUT a: LEN=16, NCH=4, default masks. DUT b: LEN=5, NCH=3, custom masks.
module tb_skipring_mc;

  typedef struct packed {
    logic [3:0] ce;
    logic       st;
    logic [3:0] pos;
    logic [3:0] pend;
    logic       run;
  } exp_a_t;

  typedef struct packed {
    logic [2:0] ce;
    logic       st;
    logic [2:0] pos;
    logic [2:0] pend;
  } exp_b_t;

  localparam logic [14:0] B_DEF = {5'b00011, 5'b10101, 5'b01010};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exp_a_t qa[$];
  exp_b_t qb[$];

  // reference state for DUT a
  logic [15:0] m_act [4];
  logic [15:0] m_sh  [4];
  logic [3:0]  m_pend;
  int          m_pos;
  logic        m_armed;

  // reference state for DUT b
  logic [4:0] bm [3];
  int         bp;

  skipring_mc_if #(.LEN(16), .NCH(4)) ifa ();
  skipring_mc_if #(.LEN(5),  .NCH(3)) ifb ();

  skipring_mc #(.LEN(16), .NCH(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  skipring_mc #(.LEN(5), .NCH(3), .DEF_MASK(B_DEF)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_act[c] = 16'hCCCC;
      m_sh[c]  = 16'hCCCC;
    end
    m_pend  = '0;
    m_pos   = 0;
    m_armed = 1'b0;
    bm[0] = B_DEF[4:0];
    bm[1] = B_DEF[9:5];
    bm[2] = B_DEF[14:10];
    bp = 0;
  endtask

  task automatic model_a(output exp_a_t x);
    logic run_now, stp, wrp;
    int   w;
    run_now = !ifa.mode || m_armed;
    stp = ifa.e && run_now;
    wrp = stp && (m_pos == 15);
    x = '0;
    if (stp) for (int c = 0; c < 4; c++) x.ce[c] = m_act[c][m_pos];
    x.st = wrp;
    if (wrp) begin
      for (int c = 0; c < 4; c++) begin
        if (m_pend[c]) begin
          m_act[c]  = m_sh[c];
          m_pend[c] = 1'b0;
        end
      end
    end
    if (ifa.wr) begin
      w = int'(ifa.wch);
      if (ifa.wimm) begin
        m_act[w]  = ifa.wmask;
        m_pend[w] = 1'b0;
      end else begin
        m_sh[w]   = ifa.wmask;
        m_pend[w] = 1'b1;
      end
    end
    if (stp) m_pos = wrp ? 0 : m_pos + 1;
    if (!m_armed && ifa.mode && ifa.go) m_armed = 1'b1;
    else if (m_armed && wrp) m_armed = 1'b0;
    x.pos  = 4'(m_pos);
    x.pend = m_pend;
    x.run  = !ifa.mode || m_armed;
  endtask

  // one clock of DUT a: predict, push, clock, pop and compare
  task automatic cyc();
    exp_a_t x, g;
    model_a(x);
    qa.push_back(x);
    @(posedge clk);
    #1;
    g = qa.pop_front();
    chk("a_ce",   32'(ifa.ce),   32'(g.ce));
    chk("a_st",   32'(ifa.st),   32'(g.st));
    chk("a_pos",  32'(ifa.pos),  32'(g.pos));
    chk("a_pend", 32'(ifa.pend), 32'(g.pend));
    chk("a_run",  32'(ifa.run),  32'(g.run));
    @(negedge clk);
    ifa.wr = 1'b0;
    ifa.go = 1'b0;
  endtask

  task automatic bcyc(input logic ev);
    exp_b_t x, g;
    ifb.e = ev;
    x = '0;
    if (ev) begin
      for (int c = 0; c < 3; c++) x.ce[c] = bm[c][bp];
      x.st = (bp == 4);
      bp = (bp == 4) ? 0 : bp + 1;
    end
    x.pos = 3'(bp);
    qb.push_back(x);
    @(posedge clk);
    #1;
    g = qb.pop_front();
    chk("b_ce",   32'(ifb.ce),   32'(g.ce));
    chk("b_st",   32'(ifb.st),   32'(g.st));
    chk("b_pos",  32'(ifb.pos),  32'(g.pos));
    chk("b_pend", 32'(ifb.pend), 32'(g.pend));
    @(negedge clk);
    ifb.wr = 1'b0;
  endtask

  initial begin
    int st_cnt, ce2_cnt;
    ifa.e = 1'b0; ifa.mode = 1'b0; ifa.go = 1'b0; ifa.wr = 1'b0;
    ifa.wch = '0; ifa.wimm = 1'b0; ifa.wmask = '0;
    ifb.e = 1'b0; ifb.mode = 1'b0; ifb.go = 1'b0; ifb.wr = 1'b0;
    ifb.wch = '0; ifb.wimm = 1'b0; ifb.wmask = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ce",   32'(ifa.ce),   32'h0);
    chk("rst_st",   32'(ifa.st),   32'h0);
    chk("rst_pos",  32'(ifa.pos),  32'h0);
    chk("rst_pend", 32'(ifa.pend), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: continuous, constant step request; ch0 pattern 0,0,1,1
    ifa.e = 1'b1;
    for (int i = 0; i < 36; i++) begin
      cyc();
      chk("t1_ce0", 32'(ifa.ce[0]), 32'((i % 4) >= 2));
      chk("t1_st",  32'(ifa.st),    32'((i % 16) == 15));
    end

    // 2: deferred write ch1 at pos 5
    for (int i = 0; i < 20 && m_pos != 5; i++) cyc();
    chk("t2_at5", 32'(ifa.pos), 32'd5);
    ifa.wr = 1'b1; ifa.wch = 2'd1; ifa.wimm = 1'b0; ifa.wmask = 16'h0001;
    cyc();
    chk("t2_pend1", 32'(ifa.pend[1]), 32'h1);
    repeat (40) cyc();

    // 3: immediate write ch2 at pos 7
    for (int i = 0; i < 20 && m_pos != 7; i++) cyc();
    ifa.wr = 1'b1; ifa.wch = 2'd2; ifa.wimm = 1'b1; ifa.wmask = 16'hFFFF;
    cyc();
    chk("t3_pend2", 32'(ifa.pend[2]), 32'h0);
    repeat (20) cyc();

    // 4: switch to one-shot mid-ring, finish the ring, then one full pass
    for (int i = 0; i < 20 && m_pos != 9; i++) cyc();
    ifa.mode = 1'b1;
    repeat (3) cyc();
    chk("t4_halt", 32'(ifa.pos), 32'd9);
    ifa.go = 1'b1;
    cyc();
    for (int i = 0; i < 20 && ifa.run; i++) cyc();
    chk("t4_park", 32'(ifa.pos), 32'd0);
    ifa.go = 1'b1;
    cyc();
    st_cnt = 0; ce2_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) ifa.go = 1'b1;
      cyc();
      if (ifa.st) st_cnt++;
      if (ifa.ce[2]) ce2_cnt++;
    end
    chk("t4_st_cnt",  32'(st_cnt),  32'd1);
    chk("t4_steps",   32'(ce2_cnt), 32'd16);
    chk("t4_run_off", 32'(ifa.run), 32'h0);
    chk("t4_pos0",    32'(ifa.pos), 32'd0);
    ifa.mode = 1'b0;
    repeat (4) cyc();

    // 6: deferred write landing on the wrap step, then mid-ring reset
    for (int i = 0; i < 20 && m_pos != 10; i++) cyc();
    ifa.wr = 1'b1; ifa.wch = 2'd3; ifa.wimm = 1'b0; ifa.wmask = 16'h00F0;
    cyc();
    for (int i = 0; i < 20 && m_pos != 15; i++) cyc();
    ifa.wr = 1'b1; ifa.wch = 2'd3; ifa.wimm = 1'b0; ifa.wmask = 16'h0F00;
    cyc();
    chk("t6_pend_kept", 32'(ifa.pend[3]), 32'h1);
    repeat (16) cyc();
    chk("t6_pend_done", 32'(ifa.pend[3]), 32'h0);
    ifa.wr = 1'b1; ifa.wch = 2'd0; ifa.wimm = 1'b0; ifa.wmask = 16'h1234;
    cyc();
    for (int i = 0; i < 20 && m_pos != 6; i++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ce",   32'(ifa.ce),   32'h0);
    chk("t6_rst_pos",  32'(ifa.pos),  32'h0);
    chk("t6_rst_pend", 32'(ifa.pend), 32'h0);
    chk("t6_rst_st",   32'(ifa.st),   32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cyc();
    ifa.e = 1'b0;
    cyc();

    // 5: LEN=5, NCH=3, toggling step request, out-of-range channel writes
    for (int i = 0; i < 16; i++) bcyc(1'(i % 2 == 0));
    ifb.wr = 1'b1; ifb.wch = 2'd3; ifb.wimm = 1'b1; ifb.wmask = 5'b11111;
    bcyc(1'b1);
    ifb.wr = 1'b1; ifb.wch = 2'd3; ifb.wimm = 1'b0; ifb.wmask = 5'b11111;
    bcyc(1'b0);
    for (int i = 0; i < 22; i++) bcyc(1'(i % 2 == 0));
    ifb.wr = 1'b1; ifb.wch = 2'd2; ifb.wimm = 1'b1; ifb.wmask = 5'b10000;
    bm[2] = 5'b10000;
    bcyc(1'b0);
    for (int i = 0; i < 12; i++) bcyc(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
